// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Collects a decoder-specified number of big-endian operand bytes
//            from the IRAM byte stream and presents one optionally
//            sign-extended operand word over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 4,
    parameter int CNT_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_W-1:0]          op_len,
    input  logic                      op_sext,
    input  logic                      abort,
    input  logic [DATA_W-1:0]         iram_data,
    input  logic                      iram_valid,
    output logic                      iram_ready,
    output logic [MAX_OPS*DATA_W-1:0] operand,
    output logic [CNT_W-1:0]          operand_len,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          remaining,
    output logic                      busy,
    output logic                      len_err
);

    localparam int               c_ACC_W   = MAX_OPS * DATA_W;
    localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]   r_len;
    logic               r_sext;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_len_err;

    logic               w_xfer;
    logic               w_start_ok;
    logic               w_len_bad;
    logic               w_sign;
    logic [c_ACC_W-1:0] w_operand;

    // A new start is only considered when the output slot is free or being
    // drained this very cycle; abort overrides everything.
    assign w_len_bad  = (op_len > c_MAX_LEN);
    assign w_start_ok = start && !abort &&
                        ((r_state == c_ST_IDLE) ||
                         ((r_state == c_ST_HOLD) && out_ready));
    assign w_xfer     = (r_state == c_ST_FETCH) && iram_valid && !abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok && !w_len_bad) begin
                    w_state_nxt = (op_len == '0) ? c_ST_HOLD : c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_xfer && (r_remaining == c_ONE)) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (out_ready) begin
                    if (w_start_ok && !w_len_bad) begin
                        w_state_nxt = (op_len == '0) ? c_ST_HOLD : c_ST_FETCH;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        iram_ready  = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        operand     = '0;
        operand_len = '0;
        case (r_state)
            c_ST_FETCH: begin
                iram_ready = 1'b1;
                busy       = 1'b1;
            end
            c_ST_HOLD: begin
                out_valid   = 1'b1;
                busy        = 1'b1;
                operand     = w_operand;
                operand_len = r_len;
            end
            default: ;
        endcase
    end

    assign remaining = r_remaining;
    assign len_err   = r_len_err;

    // ------------------------------------------------------------------
    // Datapath: accumulator, latched length/sext, byte counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_len       <= '0;
            r_sext      <= 1'b0;
            r_remaining <= '0;
            r_len_err   <= 1'b0;
        end else if (abort) begin
            r_acc       <= '0;
            r_len       <= '0;
            r_sext      <= 1'b0;
            r_remaining <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= w_start_ok && w_len_bad;
            if (w_start_ok && !w_len_bad) begin
                r_acc       <= '0;
                r_len       <= op_len;
                r_sext      <= op_sext;
                r_remaining <= op_len;
            end else if (w_xfer) begin
                r_acc       <= (r_acc << DATA_W) | c_ACC_W'(iram_data);
                r_remaining <= r_remaining - c_ONE;
            end
        end
    end

    // Sign bit is the MSB of the first-arrived byte, which sits in lane len-1.
    always_comb begin
        w_sign = 1'b0;
        for (int i = 0; i < MAX_OPS; i++) begin
            if (r_len == CNT_W'(i + 1)) begin
                w_sign = r_acc[i*DATA_W + DATA_W - 1];
            end
        end
    end

    for (genvar g = 0; g < MAX_OPS; g++) begin : g_lane
        localparam logic [CNT_W-1:0] c_LANE = CNT_W'(g);
        assign w_operand[g*DATA_W +: DATA_W] =
            (c_LANE < r_len) ? r_acc[g*DATA_W +: DATA_W]
                             : {DATA_W{r_sext & w_sign}};
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed vector bench for operand_fetch (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op_len;
    logic        op_sext;
    logic        abort;
    logic [7:0]  iram_data;
    logic        iram_valid;
    logic        iram_ready;
    logic [31:0] operand;
    logic [2:0]  operand_len;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  remaining;
    logic        busy;
    logic        len_err;

    int tests_run;
    int tests_failed;

    operand_fetch #(.DATA_W(8), .MAX_OPS(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_len      (op_len),
        .op_sext     (op_sext),
        .abort       (abort),
        .iram_data   (iram_data),
        .iram_valid  (iram_valid),
        .iram_ready  (iram_ready),
        .operand     (operand),
        .operand_len (operand_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .remaining   (remaining),
        .busy        (busy),
        .len_err     (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [2:0]  len;
        logic        sext;
        logic        abort;
        logic [7:0]  data;
        logic        dv;
        logic        ordy;
        logic        e_ird;
        logic        e_ov;
        logic [31:0] e_op;
        logic [2:0]  e_olen;
        logic [2:0]  e_rem;
        logic        e_busy;
        logic        e_lerr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic st, input logic [2:0] ln, input logic sx,
                                input logic ab, input logic [7:0] d, input logic dv,
                                input logic ordy, input logic e_ird, input logic e_ov,
                                input logic [31:0] e_op, input logic [2:0] e_olen,
                                input logic [2:0] e_rem, input logic e_busy,
                                input logic e_lerr);
        vec_t v;
        v.start = st;  v.len = ln;   v.sext = sx;   v.abort = ab;
        v.data = d;    v.dv = dv;    v.ordy = ordy;
        v.e_ird = e_ird; v.e_ov = e_ov; v.e_op = e_op; v.e_olen = e_olen;
        v.e_rem = e_rem; v.e_busy = e_busy; v.e_lerr = e_lerr;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s (step %0d): got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic ird, input logic ov,
                           input logic [31:0] op, input logic [2:0] olen,
                           input logic [2:0] rem, input logic bsy, input logic lerr);
        chk("iram_ready",  idx, {31'd0, iram_ready}, {31'd0, ird});
        chk("out_valid",   idx, {31'd0, out_valid},  {31'd0, ov});
        chk("operand",     idx, operand,             op);
        chk("operand_len", idx, {29'd0, operand_len}, {29'd0, olen});
        chk("remaining",   idx, {29'd0, remaining},  {29'd0, rem});
        chk("busy",        idx, {31'd0, busy},       {31'd0, bsy});
        chk("len_err",     idx, {31'd0, len_err},    {31'd0, lerr});
    endtask

    task automatic drive_idle();
        start = 1'b0; op_len = 3'd0; op_sext = 1'b0; abort = 1'b0;
        iram_data = 8'h00; iram_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        drive_idle();
        iram_valid = 1'b1;
        iram_data  = 8'hA5;
        reset      = 1'b0;

        // Reset held with a streaming byte source
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_all(-1 - i, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_idle();

        // Columns: start len sext abort data dv ordy | ird ov operand olen rem busy lerr
        add(1,2,0,0,8'h00,0,0, 1,0,32'h0,        0,2,1,0);
        add(0,0,0,0,8'h12,1,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h34,1,0, 0,1,32'h00001234, 2,0,1,0);
        add(0,0,0,0,8'h99,1,0, 0,1,32'h00001234, 2,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,2,1,0,8'h00,0,0, 1,0,32'h0,        0,2,1,0);
        add(0,0,0,0,8'hFF,1,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h55,0,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h55,0,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h55,0,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h80,1,0, 0,1,32'hFFFFFF80, 2,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,0,1,0,8'h00,0,0, 0,1,32'h0,        0,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,5,0,0,8'h00,0,0, 0,0,32'h0,        0,0,0,1);
        add(0,0,0,0,8'h00,0,0, 0,0,32'h0,        0,0,0,0);
        add(1,1,0,0,8'h00,0,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h9C,1,0, 0,1,32'h0000009C, 1,0,1,0);
        add(1,1,1,0,8'h00,0,1, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h7F,1,0, 0,1,32'h0000007F, 1,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,3,0,0,8'h00,0,0, 1,0,32'h0,        0,3,1,0);
        add(0,0,0,0,8'h11,1,0, 1,0,32'h0,        0,2,1,0);
        add(0,0,0,1,8'h22,1,0, 0,0,32'h0,        0,0,0,0);
        add(0,0,0,0,8'h33,1,0, 0,0,32'h0,        0,0,0,0);
        add(1,1,0,0,8'h00,0,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'hAB,1,0, 0,1,32'h000000AB, 1,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,3,1,0,8'h00,0,0, 1,0,32'h0,        0,3,1,0);
        add(0,0,0,0,8'h80,1,0, 1,0,32'h0,        0,2,1,0);
        add(0,0,0,0,8'h01,1,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'h02,1,0, 0,1,32'hFF800102, 3,0,1,0);
        add(1,1,0,0,8'h00,0,0, 0,1,32'hFF800102, 3,0,1,0);
        add(0,0,0,0,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,4,0,0,8'h00,0,0, 1,0,32'h0,        0,4,1,0);
        add(1,1,0,0,8'hDE,1,0, 1,0,32'h0,        0,3,1,0);
        add(0,0,0,0,8'hAD,1,0, 1,0,32'h0,        0,2,1,0);
        add(0,0,0,0,8'hBE,1,0, 1,0,32'h0,        0,1,1,0);
        add(0,0,0,0,8'hEF,1,0, 0,1,32'hDEADBEEF, 4,0,1,0);
        add(1,1,0,1,8'h00,0,1, 0,0,32'h0,        0,0,0,0);
        add(1,5,0,1,8'h00,0,0, 0,0,32'h0,        0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].start; op_len = tbl[i].len; op_sext = tbl[i].sext;
            abort = tbl[i].abort; iram_data = tbl[i].data;
            iram_valid = tbl[i].dv; out_ready = tbl[i].ordy;
            @(posedge clk); #1;
            chk_all(i, tbl[i].e_ird, tbl[i].e_ov, tbl[i].e_op, tbl[i].e_olen,
                    tbl[i].e_rem, tbl[i].e_busy, tbl[i].e_lerr);
        end

        // Asynchronous reset mid-fetch discards the partial operand
        @(negedge clk);
        drive_idle();
        start = 1'b1; op_len = 3'd2;
        @(negedge clk);
        drive_idle();
        iram_valid = 1'b1; iram_data = 8'h5A;
        @(posedge clk); #1;
        chk_all(100, 1'b1, 1'b0, 32'h0, 3'd0, 3'd1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #2;
        chk_all(101, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        iram_data = 8'hC3;
        @(posedge clk); #1;
        chk_all(102, 1'b0, 1'b0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
